// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multi-word CLA add/subtract sequencer.
// Holds the adder slice width, the largest supported word count and
// the sequencer state encoding.
package cla_seq_pkg;

  localparam int WORD_W    = 16;
  localparam int MAX_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_seq_ctrl_cla16.sv
// CLA_16bits: the shared 16-bit carry-lookahead adder.
// Four 4-bit lookahead groups, with group carries resolved by a
// second lookahead level, so no carry ripples between bits or groups.
module CLA_16bits
  import cla_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  logic [WORD_W-1:0] gen;
  logic [WORD_W-1:0] prop;
  logic [WORD_W-1:0] bitCarry;
  logic [3:0]        grpG;
  logic [3:0]        grpP;
  logic [4:0]        grpC;

  // Bit generate/propagate, group terms, group carries, then bit carries and sum
  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    grpG     = '0;
    grpP     = '0;
    grpC     = '0;
    bitCarry = '0;

    for (int g = 0; g < 4; g++) begin
      grpG[g] = gen[4*g+3]
              | (prop[4*g+3] & gen[4*g+2])
              | (prop[4*g+3] & prop[4*g+2] & gen[4*g+1])
              | (prop[4*g+3] & prop[4*g+2] & prop[4*g+1] & gen[4*g]);
      grpP[g] = &prop[4*g +: 4];
    end

    grpC[0] = cin_i;
    grpC[1] = grpG[0] | (grpP[0] & cin_i);
    grpC[2] = grpG[1] | (grpP[1] & grpG[0]) | (grpP[1] & grpP[0] & cin_i);
    grpC[3] = grpG[2] | (grpP[2] & grpG[1]) | (grpP[2] & grpP[1] & grpG[0])
            | (grpP[2] & grpP[1] & grpP[0] & cin_i);
    grpC[4] = grpG[3] | (grpP[3] & grpG[2]) | (grpP[3] & grpP[2] & grpG[1])
            | (grpP[3] & grpP[2] & grpP[1] & grpG[0])
            | (grpP[3] & grpP[2] & grpP[1] & grpP[0] & cin_i);

    for (int g = 0; g < 4; g++) begin
      bitCarry[4*g]   = grpC[g];
      bitCarry[4*g+1] = gen[4*g] | (prop[4*g] & grpC[g]);
      bitCarry[4*g+2] = gen[4*g+1] | (prop[4*g+1] & gen[4*g])
                      | (prop[4*g+1] & prop[4*g] & grpC[g]);
      bitCarry[4*g+3] = gen[4*g+2] | (prop[4*g+2] & gen[4*g+1])
                      | (prop[4*g+2] & prop[4*g+1] & gen[4*g])
                      | (prop[4*g+2] & prop[4*g+1] & prop[4*g] & grpC[g]);
    end

    sum_o  = prop ^ bitCarry;
    cout_o = grpC[4];
  end

endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: multi-word add/subtract sequencer around one CLA_16bits.
// One 16-bit slice is summed per clock, least significant word first,
// with the slice carry chained through a register. Subtraction is done
// as A + ~B + 1. Result, carry and signed overflow are offered over an
// output valid/ready handshake and held until taken.
// Optional feature macro: CLA_SEQ_ZERO_FLAG_EN adds a 'zero' output that
// is set when every result slice of the operation was zero.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] op_a,
  input  logic [WORD_W*WORDS-1:0] op_b,
  input  logic                    op_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] result,
  output logic                    carry_out,
  output logic                    overflow
`ifdef CLA_SEQ_ZERO_FLAG_EN
  ,
  output logic                    zero
`endif
);

  localparam int DATA_W = WORD_W * WORDS;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e            state_q;
  logic [DATA_W-1:0] opA_q;
  logic [DATA_W-1:0] opB_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] result_q;
  logic              carryOut_q;
  logic              overflow_q;
  logic              inReady_q;
  logic              outValid_q;

  logic [WORD_W-1:0] sliceA_d;
  logic [WORD_W-1:0] sliceB_d;
  logic [WORD_W-1:0] sliceSum_d;
  logic              carry_d;
  logic              overflow_d;

  assign sliceA_d = opA_q[idx_q*WORD_W +: WORD_W];
  assign sliceB_d = opB_q[idx_q*WORD_W +: WORD_W];

  CLA_16bits uAdder (
    .a_i    (sliceA_d),
    .b_i    (sliceB_d),
    .cin_i  (carry_q),
    .sum_o  (sliceSum_d),
    .cout_o (carry_d)
  );

  // Carry into the sign bit is recovered from a^b^s, then compared with carry out
  assign overflow_d = sliceA_d[WORD_W-1] ^ sliceB_d[WORD_W-1]
                    ^ sliceSum_d[WORD_W-1] ^ carry_d;

  // Sequencer FSM: accept, step one slice per cycle, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      result_q   <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && inReady_q) begin
            opA_q     <= op_a;
            opB_q     <= op_sub ? ~op_b : op_b;
            carry_q   <= op_sub;
            idx_q     <= '0;
            inReady_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          result_q[idx_q*WORD_W +: WORD_W] <= sliceSum_d;
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            carryOut_q <= carry_d;
            overflow_q <= overflow_d;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

`ifdef CLA_SEQ_ZERO_FLAG_EN
  logic zero_q;

  // Running AND of "slice is zero", primed on accept and frozen outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (state_q == IDLE && in_valid && inReady_q) begin
      zero_q <= 1'b1;
    end else if (state_q == RUN) begin
      zero_q <= zero_q & (sliceSum_d == '0);
    end
  end

  assign zero = zero_q;
`endif

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign result    = result_q;
  assign carry_out = carryOut_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed testbench for cla_seq_ctrl with WORDS = 4.
// Expected values are hand-computed 64-bit results.
module tb_cla_seq_ctrl;

  localparam int WORDS = 4;
  localparam int DW    = 16 * WORDS;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          carry_out;
  logic          overflow;
`ifdef CLA_SEQ_ZERO_FLAG_EN
  logic          zero;
`endif

  int compared   = 0;
  int mismatched = 0;

  cla_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
`ifdef CLA_SEQ_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge and let it be accepted on the next posedge
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), check latency and result, then complete the handshake
  task automatic waitResult(input string tag, input logic [DW-1:0] expRes,
                            input logic expC, input logic expV);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 20);
    checkOutput({tag, "_latency"}, 64'(cnt - 1), 64'(WORDS));
    checkOutput({tag, "_result"}, 64'(result), 64'(expRes));
    checkOutput({tag, "_carry"}, 64'(carry_out), 64'(expC));
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'(expV));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    #2;
    rst_n = 1'b0;

    // Reset held with random inputs toggling
    repeat (3) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      op_sub    = 1'($urandom);
      op_a      = {$urandom, $urandom};
      op_b      = {$urandom, $urandom};
    end
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_carry", 64'(carry_out), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;

    // Carry crossing a slice boundary
    applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    waitResult("add_ffff", 64'h0000_0000_0001_0000, 1'b0, 1'b0);

    // Full wrap to zero
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    waitResult("add_wrap", 64'h0, 1'b1, 1'b0);

    // Positive overflow
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    waitResult("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Negative overflow on subtract, no borrow
    applyStimulus(64'h8000_0000_0000_0000, 64'h1, 1'b1);
    waitResult("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Borrow out of the top word
    applyStimulus(64'h0, 64'h1, 1'b1);
    waitResult("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // Backpressure: DONE is held while in_valid pulses with other operands
    applyStimulus(64'h1111_0000_0000_1111, 64'h2222_0000_0000_2222, 1'b0);
    begin
      int cnt;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!out_valid && cnt < 20);
      checkOutput("bp_latency", 64'(cnt - 1), 64'(WORDS));
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op_a     = 64'hAAAA_AAAA_AAAA_AAAA;
      op_b     = 64'h5555_5555_5555_5555;
      op_sub   = 1'b0;
      @(negedge clk);
      checkOutput("bp_result_stable", 64'(result), 64'h3333_0000_0000_3333);
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid_held", 64'(out_valid), 64'd1);
    end
    // Pending request waits through the DONE->IDLE cycle, then is taken
    op_a      = 64'h0100;
    op_b      = 64'h0023;
    op_sub    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_idle_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_pending_accepted", 64'(in_ready), 64'd0);
    begin
      int cnt;
      cnt = 1;
      while (!out_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      checkOutput("bp_pending_latency", 64'(cnt - 1), 64'(WORDS));
      checkOutput("bp_pending_result", 64'(result), 64'h0123);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end

    // Reset after two RUN cycles aborts the op immediately
    applyStimulus(64'h1111_2222_3333_4444, 64'h1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_result", 64'(result), 64'd0);
    checkOutput("abort_carry", 64'(carry_out), 64'd0);
    checkOutput("abort_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(64'h1234, 64'h1, 1'b0);
    waitResult("post_abort", 64'h1235, 1'b0, 1'b0);

`ifdef CLA_SEQ_ZERO_FLAG_EN
    applyStimulus(64'h5, 64'h5, 1'b1);
    begin
      int cnt;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!out_valid && cnt < 20);
      checkOutput("zero_result", 64'(result), 64'h0);
      checkOutput("zero_flag_set", 64'(zero), 64'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    applyStimulus(64'h1_0000, 64'h0, 1'b0);
    waitResult("nonzero", 64'h1_0000, 1'b0, 1'b0);
    checkOutput("zero_flag_clear", 64'(zero), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
